arm_pipelined_ldm_stm_sequencer: RTL and testbench
==================================================

# arm_pipelined_ldm_stm_sequencer

Multi-cycle sequencer for ARM block transfers (LDM/STM). It sits beside the decode stage and drives the register-file read port, register-file write port and data-memory port for one register per cycle. It stalls the pipeline until the whole transfer list and optional base writeback are complete. R15 reads come from the register file's PC mux; LDM loads into R15 are steered to the PC path.

## Interface
- BusWidth, 32, data/address width
- RegAddrWidth, 4, register address width
- i_CLK  in  1  clock, rising edge
- i_NRESET  in  1  asynchronous active-low reset
- i_Start  in  1  LDM/STM present in decode; sampled only in IDLE
- i_Load  in  1  L bit: 1 = LDM, 0 = STM
- i_PreIndex  in  1  P bit
- i_Up  in  1  U bit
- i_WriteBack  in  1  W bit
- i_BaseAddr  in  RegAddrWidth  Rn
- i_BaseValue  in  BusWidth  value of Rn, valid with i_Start
- i_RegList  in  16  register list, bit k = Rk
- o_RegRead_Addr  out  RegAddrWidth  register-file read address (STM)
- i_RegRead_Data  in  BusWidth  register-file read data, combinational
- o_RegWrite_Enable  out  1  register-file write strobe
- o_RegWrite_Addr  out  RegAddrWidth  register-file write address
- o_RegWrite_Data  out  BusWidth  register-file write data
- o_PCLoad  out  1  LDM loaded R15; value is on o_RegWrite_Data
- o_MemAddr  out  BusWidth  word address
- o_MemWriteEnable  out  1  memory write strobe
- o_MemReadEnable  out  1  memory read strobe
- o_MemWriteData  out  BusWidth  store data
- i_MemReadData  in  BusWidth  load data, valid in the same cycle as o_MemAddr
- o_Stall  out  1  hold fetch/decode
- o_Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, TRANSFER, WRITEBACK, DONE.
- Registered state: Remaining list (16 bits), current address, final base, latched L/W/Rn.
- Count N = popcount(i_RegList), range 0..16, 5 bits. All address arithmetic is modulo 2^BusWidth and wraps silently.
- Start address by (P,U):
  - IA (0,1): Base
  - IB (1,1): Base+4
  - DA (0,0): Base-4N+4
  - DB (1,0): Base-4N
- Final base: U ? Base+4N : Base-4N.
- Transfer order is always lowest register at lowest address, with addresses ascending by 4.
- IDLE: all outputs 0.
  - i_Start with N>0: latch operands, go to TRANSFER.
  - i_Start with N=0: go to DONE; no transfer, no writeback.
- TRANSFER, each cycle, acting on k = lowest set bit of Remaining:
  - o_MemAddr = current address.
  - STM: o_RegRead_Addr=k, o_MemWriteData=i_RegRead_Data, o_MemWriteEnable=1.
  - LDM with k<15: o_MemReadEnable=1, o_RegWrite_Enable=1, o_RegWrite_Addr=k, o_RegWrite_Data=i_MemReadData.
  - LDM with k=15: o_MemReadEnable=1, o_RegWrite_Enable=0, o_PCLoad=1, o_RegWrite_Data=i_MemReadData.
  - At the clock edge: clear bit k, address += 4.
  - After the last bit: go to WRITEBACK if W=1, otherwise go to DONE.
- WRITEBACK: o_RegWrite_Enable=1, o_RegWrite_Addr=Rn, o_RegWrite_Data=final base, then go to DONE.
  - Suppressed (enable 0) when LDM has Rn in the list, because the loaded value wins.
  - Suppressed when Rn=15.
- DONE: o_Done=1, o_Stall=0, return to IDLE. i_Start is ignored in this state.
- o_Stall = 1 in TRANSFER and WRITEBACK, 0 otherwise.
- All outputs are combinational from registered state plus the listed data inputs.

## Timing
- Reset: asynchronous to IDLE, Remaining=0. Every output is 0 while reset is asserted and on release.
- Reset mid-operation: abort immediately. No further strobes; the partial transfer is not undone.
- Latency from the i_Start cycle:
  - TRANSFER occupies cycles 1..N.
  - WRITEBACK at N+1 if performed.
  - DONE at N+1 without writeback, N+2 with it.
  - N=0: DONE at cycle 1.
- Exactly one memory strobe per TRANSFER cycle. Never a memory strobe and a writeback in the same cycle.
- i_BaseValue, i_RegList and control bits are sampled only on the accepting IDLE edge. Later changes are ignored.

## Test plan
- STMIA R0!,{R1,R2,R4}, Base=0x100: writes to 0x100/0x104/0x108 carry R1/R2/R4 data; R0←0x10C at cycle 4; o_Done at cycle 5; o_Stall high cycles 1–4.
- LDMDB R13!,{R4-R7}, Base=0x200: reads 0x1F0..0x1FC into R4..R7; R13←0x1F0; o_Done at cycle 6.
- LDMIA R2!,{R1,R2,R3}, Base=0x40: R2 gets the memory word from 0x44; no writeback cycle; o_Done at cycle 4.
- LDMIB R0,{R0-R15} (list 0xFFFF), Base=0: 16 reads at 0x4..0x40; R15 cycle has o_PCLoad=1 and write enable 0; no writeback; o_Done at cycle 17.
- STMDA with empty list and W=1: o_Done at cycle 1; no memory or register strobes.
- i_NRESET low during the 2nd cycle of a 4-register STM: strobes drop asynchronously; after release, idle with all outputs 0; a new i_Start is accepted.

Source files
------------

// File: rtl/arm_pipelined_ldm_stm_sequencer_if.sv
// Decode-side request, register-file ports and data-memory port of the LDM/STM sequencer.
// master = sequencer view, slave = pipeline/memory view.
interface arm_pipelined_ldm_stm_sequencer_if #(
  parameter int BusWidth     = 32,
  parameter int RegAddrWidth = 4
);
  logic                    i_Start;
  logic                    i_Load;
  logic                    i_PreIndex;
  logic                    i_Up;
  logic                    i_WriteBack;
  logic [RegAddrWidth-1:0] i_BaseAddr;
  logic [BusWidth-1:0]     i_BaseValue;
  logic [15:0]             i_RegList;

  logic [RegAddrWidth-1:0] o_RegRead_Addr;
  logic [BusWidth-1:0]     i_RegRead_Data;
  logic                    o_RegWrite_Enable;
  logic [RegAddrWidth-1:0] o_RegWrite_Addr;
  logic [BusWidth-1:0]     o_RegWrite_Data;
  logic                    o_PCLoad;

  logic [BusWidth-1:0]     o_MemAddr;
  logic                    o_MemWriteEnable;
  logic                    o_MemReadEnable;
  logic [BusWidth-1:0]     o_MemWriteData;
  logic [BusWidth-1:0]     i_MemReadData;

  logic                    o_Stall;
  logic                    o_Done;

  modport master (
    input  i_Start, i_Load, i_PreIndex, i_Up, i_WriteBack, i_BaseAddr, i_BaseValue, i_RegList,
    input  i_RegRead_Data, i_MemReadData,
    output o_RegRead_Addr, o_RegWrite_Enable, o_RegWrite_Addr, o_RegWrite_Data, o_PCLoad,
    output o_MemAddr, o_MemWriteEnable, o_MemReadEnable, o_MemWriteData, o_Stall, o_Done
  );

  modport slave (
    output i_Start, i_Load, i_PreIndex, i_Up, i_WriteBack, i_BaseAddr, i_BaseValue, i_RegList,
    output i_RegRead_Data, i_MemReadData,
    input  o_RegRead_Addr, o_RegWrite_Enable, o_RegWrite_Addr, o_RegWrite_Data, o_PCLoad,
    input  o_MemAddr, o_MemWriteEnable, o_MemReadEnable, o_MemWriteData, o_Stall, o_Done
  );
endinterface

// File: rtl/arm_pipelined_ldm_stm_sequencer.sv
// ARM LDM/STM sequencer: one register per cycle, then optional base writeback; DONE at N+1 (N+2 with writeback).
// No backpressure: memory and register file answer in the same cycle; o_Stall holds the pipeline meanwhile.
module arm_pipelined_ldm_stm_sequencer #(
  parameter int BusWidth     = 32,
  parameter int RegAddrWidth = 4
) (
  input logic                               i_CLK,
  input logic                               i_NRESET,
  arm_pipelined_ldm_stm_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, TRANSFER, WRITEBACK, DONE} state_t;

  state_t                  state;
  logic [15:0]             remaining;
  logic [BusWidth-1:0]     cur_addr;
  logic [BusWidth-1:0]     final_base;
  logic                    ld;
  logic                    wb_en;
  logic [RegAddrWidth-1:0] rn;

  logic [4:0]              count;
  logic [BusWidth-1:0]     span;
  logic [BusWidth-1:0]     start_addr;
  logic [BusWidth-1:0]     next_final;
  logic [15:0]             remaining_next;
  logic [3:0]              k;
  logic                    rn_listed;
  logic                    rn_is_pc;

  assign count          = 5'($countones(bus.i_RegList));
  assign span           = BusWidth'({count, 2'b00});
  assign next_final     = bus.i_Up ? bus.i_BaseValue + span : bus.i_BaseValue - span;
  assign remaining_next = remaining & (remaining - 16'd1);
  assign rn_listed      = bus.i_RegList[bus.i_BaseAddr];
  assign rn_is_pc       = (bus.i_BaseAddr == RegAddrWidth'(15));

  // Lowest register always goes to the lowest address, so only the start differs per mode.
  always_comb begin
    case ({bus.i_PreIndex, bus.i_Up})
      2'b01:   start_addr = bus.i_BaseValue;
      2'b11:   start_addr = bus.i_BaseValue + BusWidth'(4);
      2'b00:   start_addr = bus.i_BaseValue - span + BusWidth'(4);
      default: start_addr = bus.i_BaseValue - span;
    endcase
  end

  always_comb begin
    k = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (remaining[i]) k = 4'(i);
    end
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state      <= IDLE;
      remaining  <= '0;
      cur_addr   <= '0;
      final_base <= '0;
      ld         <= 1'b0;
      wb_en      <= 1'b0;
      rn         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_Start) begin
            remaining  <= bus.i_RegList;
            cur_addr   <= start_addr;
            final_base <= next_final;
            ld         <= bus.i_Load;
            rn         <= bus.i_BaseAddr;
            // A loaded base beats the writeback; R15 is never written back.
            wb_en      <= bus.i_WriteBack && !(bus.i_Load && rn_listed) && !rn_is_pc;
            state      <= (count == 5'd0) ? DONE : TRANSFER;
          end
        end
        TRANSFER: begin
          remaining <= remaining_next;
          cur_addr  <= cur_addr + BusWidth'(4);
          if (remaining_next == 16'd0) state <= wb_en ? WRITEBACK : DONE;
        end
        WRITEBACK: state <= DONE;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_RegRead_Addr    = '0;
    bus.o_RegWrite_Enable = 1'b0;
    bus.o_RegWrite_Addr   = '0;
    bus.o_RegWrite_Data   = '0;
    bus.o_PCLoad          = 1'b0;
    bus.o_MemAddr         = '0;
    bus.o_MemWriteEnable  = 1'b0;
    bus.o_MemReadEnable   = 1'b0;
    bus.o_MemWriteData    = '0;
    bus.o_Stall           = 1'b0;
    bus.o_Done            = 1'b0;
    case (state)
      TRANSFER: begin
        bus.o_Stall   = 1'b1;
        bus.o_MemAddr = cur_addr;
        if (ld) begin
          bus.o_MemReadEnable = 1'b1;
          bus.o_RegWrite_Data = bus.i_MemReadData;
          if (k == 4'd15) begin
            bus.o_PCLoad = 1'b1;
          end else begin
            bus.o_RegWrite_Enable = 1'b1;
            bus.o_RegWrite_Addr   = RegAddrWidth'(k);
          end
        end else begin
          bus.o_RegRead_Addr   = RegAddrWidth'(k);
          bus.o_MemWriteData   = bus.i_RegRead_Data;
          bus.o_MemWriteEnable = 1'b1;
        end
      end
      WRITEBACK: begin
        bus.o_Stall           = 1'b1;
        bus.o_RegWrite_Enable = 1'b1;
        bus.o_RegWrite_Addr   = rn;
        bus.o_RegWrite_Data   = final_base;
      end
      DONE: bus.o_Done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_arm_pipelined_ldm_stm_sequencer.sv
// Directed bench: per-cycle expected outputs queued per transfer, compared at each negedge.
module tb_arm_pipelined_ldm_stm_sequencer;
  localparam int BW = 32;
  localparam int RW = 4;

  typedef struct packed {
    logic          stall;
    logic          done;
    logic          mem_we;
    logic          mem_re;
    logic          rf_we;
    logic          pcload;
    logic [RW-1:0] rd_addr;
    logic [RW-1:0] rf_waddr;
    logic [BW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] rf_wdata;
  } obs_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  obs_t obs;

  arm_pipelined_ldm_stm_sequencer_if #(.BusWidth(BW), .RegAddrWidth(RW)) bus ();

  arm_pipelined_ldm_stm_sequencer #(.BusWidth(BW), .RegAddrWidth(RW)) dut (
    .i_CLK    (clk),
    .i_NRESET (nreset),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mem_f(input logic [BW-1:0] a);
    return a * 32'd3 + 32'h1357_0000;
  endfunction

  function automatic logic [BW-1:0] reg_f(input logic [RW-1:0] r);
    return 32'hC0DE_0000 + {28'd0, r} * 32'h0000_0111;
  endfunction

  assign bus.i_MemReadData  = mem_f(bus.o_MemAddr);
  assign bus.i_RegRead_Data = reg_f(bus.o_RegRead_Addr);

  always_comb begin
    obs.stall     = bus.o_Stall;
    obs.done      = bus.o_Done;
    obs.mem_we    = bus.o_MemWriteEnable;
    obs.mem_re    = bus.o_MemReadEnable;
    obs.rf_we     = bus.o_RegWrite_Enable;
    obs.pcload    = bus.o_PCLoad;
    obs.rd_addr   = bus.o_RegRead_Addr;
    obs.rf_waddr  = bus.o_RegWrite_Addr;
    obs.mem_addr  = bus.o_MemAddr;
    obs.mem_wdata = bus.o_MemWriteData;
    obs.rf_wdata  = bus.o_RegWrite_Data;
  end

  task automatic check(input string tag, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic l, input logic p, input logic u, input logic w,
                       input logic [RW-1:0] rn, input logic [BW-1:0] base, input logic [15:0] list);
    bus.i_Start     = st;
    bus.i_Load      = l;
    bus.i_PreIndex  = p;
    bus.i_Up        = u;
    bus.i_WriteBack = w;
    bus.i_BaseAddr  = rn;
    bus.i_BaseValue = base;
    bus.i_RegList   = list;
  endtask

  // Entered and left at posedge+1.
  task automatic run_op(input string name, input logic l, input logic p, input logic u, input logic w,
                        input logic [RW-1:0] rn, input logic [BW-1:0] base, input logic [15:0] list,
                        input logic hold_start);
    obs_t          e;
    int            n;
    int            cyc;
    logic [BW-1:0] a;
    n = $countones(list);
    e = '0;
    exp_q.push_back(e);
    if (n == 0) begin
      e.done = 1'b1;
      exp_q.push_back(e);
    end else begin
      if (u) a = p ? base + 32'd4 : base;
      else   a = p ? base - 32'(4 * n) : base - 32'(4 * (n - 1));
      for (int r = 0; r < 16; r++) begin
        if (list[r]) begin
          e = '0;
          e.stall    = 1'b1;
          e.mem_addr = a;
          if (l) begin
            e.mem_re   = 1'b1;
            e.rf_wdata = mem_f(a);
            if (r == 15) e.pcload = 1'b1;
            else begin
              e.rf_we    = 1'b1;
              e.rf_waddr = RW'(r);
            end
          end else begin
            e.mem_we    = 1'b1;
            e.rd_addr   = RW'(r);
            e.mem_wdata = reg_f(RW'(r));
          end
          exp_q.push_back(e);
          a = a + 32'd4;
        end
      end
      if (w && rn != 4'd15 && !(l && list[rn])) begin
        e = '0;
        e.stall    = 1'b1;
        e.rf_we    = 1'b1;
        e.rf_waddr = rn;
        e.rf_wdata = u ? base + 32'(4 * n) : base - 32'(4 * n);
        exp_q.push_back(e);
      end
      e = '0;
      e.done = 1'b1;
      exp_q.push_back(e);
    end
    e = '0;
    exp_q.push_back(e);

    drive(1'b1, l, p, u, w, rn, base, list);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check($sformatf("%s c%0d", name, cyc), exp_q.pop_front());
      @(posedge clk);
      #1;
      // Operands must be latched only on the accepting edge.
      if (cyc == 0) drive(hold_start, ~l, ~p, ~u, ~w, ~rn, ~base, ~list);
      if (cyc == 1 && hold_start) bus.i_Start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    obs_t e;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0);
    #3;
    check("reset held", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(negedge clk);
    check("reset release", '0);
    @(posedge clk);
    #1;

    run_op("STMIA R0!", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  32'h0000_0100, 16'h0016, 1'b0);
    run_op("LDMDB R13!", 1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_0200, 16'h00F0, 1'b0);
    run_op("LDMIA R2! own", 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0000_0040, 16'h000E, 1'b0);
    run_op("LDMIB all", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  32'h0000_0000, 16'hFFFF, 1'b0);
    run_op("STMDA empty", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_0500, 16'h0000, 1'b1);
    run_op("STMDA R5!", 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  32'h0000_1000, 16'h8009, 1'b0);
    run_op("STMDB wrap", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0000_0004, 16'h0003, 1'b0);
    run_op("STMIA R15!", 1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 32'h0000_0080, 16'h0008, 1'b0);

    // Reset during the second transfer cycle of a 4-register STM.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 32'h0000_0300, 16'h000F);
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    @(negedge clk);
    e = '0;
    e.stall     = 1'b1;
    e.mem_we    = 1'b1;
    e.mem_addr  = 32'h0000_0300;
    e.mem_wdata = reg_f(4'd0);
    check("abort c1", e);
    @(posedge clk);
    #1;
    e.mem_addr  = 32'h0000_0304;
    e.rd_addr   = 4'd1;
    e.mem_wdata = reg_f(4'd1);
    check("abort c2", e);
    #2;
    nreset = 1'b0;
    #1;
    check("abort async", '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort held", '0);
    nreset = 1'b1;
    @(negedge clk);
    check("abort release", '0);
    @(posedge clk);
    #1;
    run_op("after abort", 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h0000_0600, 16'h0021, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
